// File: rtl/controller_ram_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
package controller_ram_pkg;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_t;

  // Master port indices, also used as the grant/last-grant encoding.
  localparam logic PortM0 = 1'b0;
  localparam logic PortM1 = 1'b1;

  // Bit-reverse a 4-bit byte-enable so it follows byte-reversed data.
  function automatic logic [3:0] rev4(input logic [3:0] b);
    return {b[0], b[1], b[2], b[3]};
  endfunction

endpackage

// File: rtl/byte_swap32.sv
// Reverses the byte order of a 32-bit word (endianness swap).
module byte_swap32 (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = {din[7:0], din[15:8], din[23:16], din[31:24]};

endmodule

// File: rtl/controller_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two masters.
// Each granted access runs IDLE -> ISSUE -> (WAIT x RD_LAT) -> DONE.
module controller_ram_arbiter
  import controller_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_d,
  input  logic [3:0]        m0_bytesel,
  output logic              m0_ack,
  output logic [31:0]       m0_q,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_d,
  input  logic [3:0]        m1_bytesel,
  output logic              m1_ack,
  output logic [31:0]       m1_q,
  input  logic              m1_swap,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_d,
  output logic              ram_we,
  output logic [3:0]        ram_bytesel,
  input  logic [31:0]       ram_q
);

  state_t     state;
  logic       grant;
  logic       last_grant;
  logic       lat_we;
  logic [1:0] cnt;

  logic              pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_d;
  logic [3:0]        sel_bytesel;
  logic [31:0]       m1_d_swapped;
  logic [31:0]       ram_q_swapped;

  // Write path: m1 data byte-reversed before it reaches the RAM.
  byte_swap32 u_swap_wr (
    .din  (m1_d),
    .dout (m1_d_swapped)
  );

  // Read path: RAM data byte-reversed before it lands in m1_q.
  byte_swap32 u_swap_rd (
    .din  (ram_q),
    .dout (ram_q_swapped)
  );

  // Pick the grantee and mux its request fields; a tie goes to the port not granted last.
  always_comb begin
    pick = PortM0;
    if (m0_req && m1_req) begin
      pick = ~last_grant;
    end else if (m1_req) begin
      pick = PortM1;
    end

    sel_we      = m0_we;
    sel_addr    = m0_addr;
    sel_d       = m0_d;
    sel_bytesel = m0_bytesel;
    if (pick == PortM1) begin
      sel_we      = m1_we;
      sel_addr    = m1_addr;
      sel_d       = m1_swap ? m1_d_swapped : m1_d;
      sel_bytesel = m1_swap ? rev4(m1_bytesel) : m1_bytesel;
    end
  end

  // Sequencer: all outputs are registered; ram_we and acks default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      grant       <= PortM0;
      last_grant  <= PortM1;
      lat_we      <= 1'b0;
      cnt         <= 2'd0;
      ram_addr    <= '0;
      ram_d       <= '0;
      ram_we      <= 1'b0;
      ram_bytesel <= '0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_q        <= '0;
      m1_q        <= '0;
    end else begin
      ram_we <= 1'b0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      unique case (state)
        StIdle: begin
          if (m0_req || m1_req) begin
            grant       <= pick;
            last_grant  <= pick;
            lat_we      <= sel_we;
            ram_addr    <= sel_addr;
            ram_d       <= sel_d;
            ram_bytesel <= sel_bytesel;
            // Registered so it is high for exactly the ISSUE cycle.
            ram_we      <= sel_we;
            state       <= StIssue;
          end
        end
        StIssue: begin
          if (lat_we) begin
            // Ack is raised on entry to DONE so it is visible during DONE.
            m0_ack <= (grant == PortM0);
            m1_ack <= (grant == PortM1);
            state  <= StDone;
          end else begin
            cnt   <= 2'(RD_LAT - 1);
            state <= StWait;
          end
        end
        StWait: begin
          if (cnt == 2'd0) begin
            if (grant == PortM0) begin
              m0_q <= ram_q;
            end else begin
              m1_q <= m1_swap ? ram_q_swapped : ram_q;
            end
            m0_ack <= (grant == PortM0);
            m1_ack <= (grant == PortM1);
            state  <= StDone;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_ram_arbiter.sv
// Directed bench: table of single transactions plus hand-written tie, reset and latency cases.
module tb_controller_ram_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance with RD_LAT=1, both masters driven.
  logic        m0_req, m0_we, m1_req, m1_we, m1_swap;
  logic [11:0] m0_addr, m1_addr;
  logic [31:0] m0_d, m1_d;
  logic [3:0]  m0_bs, m1_bs;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_q, m1_q;
  logic [11:0] ram_addr;
  logic [31:0] ram_d, ram_q;
  logic        ram_we;
  logic [3:0]  ram_bs;

  // Instance with RD_LAT=3, only m0 used.
  logic        a_req;
  logic [11:0] a_addr;
  logic        a_ack, a_m1_ack;
  logic [31:0] a_q, a_m1_q;
  logic [11:0] a_ram_addr;
  logic [31:0] a_ram_d, a_ram_q;
  logic        a_ram_we;
  logic [3:0]  a_ram_bs;

  controller_ram_arbiter #(.ADDR_W(12), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_d(m0_d), .m0_bytesel(m0_bs),
    .m0_ack(m0_ack), .m0_q(m0_q),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_d(m1_d), .m1_bytesel(m1_bs),
    .m1_ack(m1_ack), .m1_q(m1_q), .m1_swap(m1_swap),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_bytesel(ram_bs), .ram_q(ram_q)
  );

  controller_ram_arbiter #(.ADDR_W(12), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .m0_req(a_req), .m0_we(1'b0), .m0_addr(a_addr), .m0_d(32'h0), .m0_bytesel(4'h0),
    .m0_ack(a_ack), .m0_q(a_q),
    .m1_req(1'b0), .m1_we(1'b0), .m1_addr(12'h0), .m1_d(32'h0), .m1_bytesel(4'h0),
    .m1_ack(a_m1_ack), .m1_q(a_m1_q), .m1_swap(1'b0),
    .ram_addr(a_ram_addr), .ram_d(a_ram_d), .ram_we(a_ram_we), .ram_bytesel(a_ram_bs),
    .ram_q(a_ram_q)
  );

  // RAM models: byte-enabled writes, 1-cycle and 3-cycle read pipelines.
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] p0, p1;

  always @(posedge clk) begin
    ram_q <= mem1[ram_addr[7:0]];
    if (reset) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 32'h0;
    end else if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_bs[b]) mem1[ram_addr[7:0]][8*b +: 8] <= ram_d[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    p0      <= mem3[a_ram_addr[7:0]];
    p1      <= p0;
    a_ram_q <= p1;
    if (reset) begin
      for (int i = 0; i < 256; i++) mem3[i] <= 32'h0;
      mem3[5] <= 32'h12345678;
    end else if (a_ram_we) begin
      for (int b = 0; b < 4; b++)
        if (a_ram_bs[b]) mem3[a_ram_addr[7:0]][8*b +: 8] <= a_ram_d[8*b +: 8];
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transaction on dut; cycle 1 is the IDLE cycle where req first goes high.
  task automatic txn(input logic port, input logic we, input logic [11:0] addr,
                     input logic [31:0] d, input logic [3:0] bs, input logic swap,
                     output int lat, output int wecnt, output logic [11:0] iaddr,
                     output logic [31:0] id, output logic [3:0] ibs, output logic [31:0] q,
                     output int other);
    @(negedge clk);
    m1_swap = swap;
    if (port) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_d = d; m1_bs = bs;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_d = d; m0_bs = bs;
    end
    lat = 0; wecnt = 0; other = 0; q = 32'h0;
    iaddr = 12'h0; id = 32'h0; ibs = 4'h0;
    for (int k = 2; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (ram_we) wecnt++;
      if (k == 2) begin
        iaddr = ram_addr; id = ram_d; ibs = ram_bs;
      end
      if (port ? m0_ack : m1_ack) other++;
      if (port ? m1_ack : m0_ack) begin
        lat = k;
        q = port ? m1_q : m0_q;
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  // Both masters request writes in the same cycle; returns the cycle each ack was seen.
  task automatic tie(output int k0, output int k1);
    @(negedge clk);
    m1_swap = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h040; m0_d = 32'h1; m0_bs = 4'hF;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 12'h041; m1_d = 32'h2; m1_bs = 4'hF;
    k0 = 0; k1 = 0;
    for (int k = 2; k <= 20 && (k0 == 0 || k1 == 0); k++) begin
      @(negedge clk);
      if (m0_ack) begin k0 = k; m0_req = 1'b0; end
      if (m1_ack) begin k1 = k; m1_req = 1'b0; end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [11:0] addr;
    logic [31:0] d;
    logic [3:0]  bs;
    logic        swap;
    logic [31:0] e_d;
    logic [3:0]  e_bs;
    logic [31:0] e_q;
    int          e_lat;
  } vec_t;

  vec_t vt [10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, wecnt, other, k0, k1, ak;
    logic [11:0] iaddr;
    logic [31:0] id, q;
    logic [3:0]  ibs;

    //             port we  addr     d             bs    swap e_d           e_bs  e_q           lat
    vt[0] = '{1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 1'b0, 32'hDEADBEEF, 4'hF, 32'h0,        3};
    vt[1] = '{1'b0, 1'b0, 12'h010, 32'h0,        4'h0, 1'b0, 32'h0,        4'h0, 32'hDEADBEEF, 4};
    vt[2] = '{1'b1, 1'b1, 12'h020, 32'h11223344, 4'h1, 1'b1, 32'h44332211, 4'h8, 32'h0,        3};
    vt[3] = '{1'b1, 1'b0, 12'h020, 32'h0,        4'h0, 1'b1, 32'h0,        4'h0, 32'h00000044, 4};
    vt[4] = '{1'b1, 1'b0, 12'h010, 32'h0,        4'h0, 1'b0, 32'h0,        4'h0, 32'hDEADBEEF, 4};
    vt[5] = '{1'b0, 1'b1, 12'h030, 32'hCAFEF00D, 4'h5, 1'b0, 32'hCAFEF00D, 4'h5, 32'h0,        3};
    vt[6] = '{1'b0, 1'b0, 12'h030, 32'h0,        4'h0, 1'b0, 32'h0,        4'h0, 32'h00FE000D, 4};
    vt[7] = '{1'b1, 1'b1, 12'h031, 32'hA1B2C3D4, 4'hC, 1'b1, 32'hD4C3B2A1, 4'h3, 32'h0,        3};
    vt[8] = '{1'b1, 1'b0, 12'h031, 32'h0,        4'h0, 1'b1, 32'h0,        4'h0, 32'hA1B20000, 4};
    vt[9] = '{1'b0, 1'b0, 12'h031, 32'h0,        4'h0, 1'b0, 32'h0,        4'h0, 32'h0000B2A1, 4};

    m0_req = 0; m0_we = 0; m0_addr = 0; m0_d = 0; m0_bs = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_d = 0; m1_bs = 0; m1_swap = 0;
    a_req = 0; a_addr = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_m0_ack", 32'(m0_ack), 32'h0);
    check("rst_m1_ack", 32'(m1_ack), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_ram_d", ram_d, 32'h0);
    check("rst_ram_bs", 32'(ram_bs), 32'h0);
    check("rst_m0_q", m0_q, 32'h0);
    check("rst_m1_q", m1_q, 32'h0);
    reset = 1'b0;

    // First tie after reset goes to m0, then m1 follows after the DONE/IDLE cycles.
    tie(k0, k1);
    check("tie1_m0_k", 32'(k0), 32'd3);
    check("tie1_m1_k", 32'(k1), 32'd6);
    // A sole m0 access makes m0 the last grantee, so the next tie goes to m1.
    txn(1'b0, 1'b1, 12'h042, 32'h3, 4'hF, 1'b0, lat, wecnt, iaddr, id, ibs, q, other);
    check("solo_lat", 32'(lat), 32'd3);
    tie(k0, k1);
    check("tie2_m1_k", 32'(k1), 32'd3);
    check("tie2_m0_k", 32'(k0), 32'd6);

    for (int i = 0; i < 10; i++) begin
      txn(vt[i].port, vt[i].we, vt[i].addr, vt[i].d, vt[i].bs, vt[i].swap,
          lat, wecnt, iaddr, id, ibs, q, other);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].e_lat));
      check($sformatf("v%0d_wecnt", i), 32'(wecnt), vt[i].we ? 32'd1 : 32'd0);
      check($sformatf("v%0d_addr", i), 32'(iaddr), 32'(vt[i].addr));
      check($sformatf("v%0d_other_ack", i), 32'(other), 32'd0);
      if (vt[i].we) begin
        check($sformatf("v%0d_ram_d", i), id, vt[i].e_d);
        check($sformatf("v%0d_ram_bs", i), 32'(ibs), 32'(vt[i].e_bs));
      end else begin
        check($sformatf("v%0d_q", i), q, vt[i].e_q);
      end
    end
    check("hold_m0_q", m0_q, 32'h0000B2A1);
    check("hold_m1_q", m1_q, 32'hA1B20000);

    // Reset during the WAIT cycle of an m1 read: no ack, no RAM write afterwards.
    @(negedge clk);
    m1_swap = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h010;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstwait_m1_ack", 32'(m1_ack), 32'h0);
    check("rstwait_ram_we", 32'(ram_we), 32'h0);
    reset = 1'b0;
    m1_req = 1'b0;
    wecnt = 0; other = 0;
    repeat (4) begin
      @(negedge clk);
      if (ram_we) wecnt++;
      if (m1_ack || m0_ack) other++;
    end
    check("rstwait_later_we", 32'(wecnt), 32'd0);
    check("rstwait_later_ack", 32'(other), 32'd0);
    check("rstwait_m1_q", m1_q, 32'h0);
    txn(1'b0, 1'b1, 12'h050, 32'h55, 4'hF, 1'b0, lat, wecnt, iaddr, id, ibs, q, other);
    check("post_rst_lat", 32'(lat), 32'd3);

    // RD_LAT=3 read with req dropped during ISSUE still completes.
    @(negedge clk);
    a_req = 1'b1; a_addr = 12'h005;
    ak = 0;
    for (int k = 2; k <= 20 && ak == 0; k++) begin
      @(negedge clk);
      if (k == 2) a_req = 1'b0;
      if (a_ack) ak = k;
    end
    check("lat3_k", 32'(ak), 32'd6);
    check("lat3_q", a_q, 32'h12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
